// File: rtl/handshake_fifo.sv
// handshake_fifo: ready/valid elastic buffer built on a DEPTH-entry circular store.
// It has an optional fall-through bypass for the empty case, an occupancy output,
// and a sticky checker that flags upstream hold-rule violations.
module handshake_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 2,
  parameter int FALLTHROUGH = 0,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LVL_W-1:0]      level,
  output logic                  proto_err
);

  // A single-entry store still needs a 1-bit pointer.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam bit FT = (FALLTHROUGH == 1);

  // Reject illegal parameterisations at elaboration.
  generate
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("handshake_fifo: DATA_WIDTH must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
      $error("handshake_fifo: DEPTH must be >= 1");
    end
    if (FALLTHROUGH != 0 && FALLTHROUGH != 1) begin : g_bad_ft
      $error("handshake_fifo: FALLTHROUGH must be 0 or 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]      level_reg, level_next;
  logic                  proto_err_reg, proto_err_next;
  logic                  prev_stall_reg, prev_stall_next;
  logic [DATA_WIDTH-1:0] prev_data_reg;

  logic full, empty, bypass, bypass_fire, push, pop;

  // Handshake decode: ready/valid outputs, bypass selection, push/pop strobes.
  always_comb begin
    full        = (level_reg == FULL_LVL);
    empty       = (level_reg == '0);
    bypass      = FT && empty;
    // in_ready depends only on occupancy, so no out_ready->in_ready path exists.
    in_ready    = !rst && !full;
    out_valid   = !rst && (bypass ? in_valid : !empty);
    out_data    = bypass ? in_data : mem[rd_ptr_reg];
    // A bypassed beat goes straight through and never touches storage.
    bypass_fire = bypass && in_valid && out_ready && !rst;
    push        = in_valid && in_ready && !bypass_fire;
    pop         = !rst && !empty && out_ready;
  end

  // Next-state for pointers, occupancy and the protocol checker.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
    // A beat stalled at the previous edge must still be offered, unchanged.
    proto_err_next  = proto_err_reg |
                      (prev_stall_reg & (!in_valid | (in_data != prev_data_reg)));
    prev_stall_next = in_valid & !in_ready;
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      proto_err_reg  <= 1'b0;
      prev_stall_reg <= 1'b0;
      prev_data_reg  <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      proto_err_reg  <= proto_err_next;
      prev_stall_reg <= prev_stall_next;
      prev_data_reg  <= in_data;
    end
  end

  // Payload storage; contents are not cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  assign level     = level_reg;
  assign proto_err = proto_err_reg;

endmodule
